// File: rtl/ccip_tx_elastic_buffer.sv
// rtl/ccip_tx_elastic_buffer.sv - elastic buffer for one CCI-P Tx channel
// Absorbs requests while the shell is almost-full; drops on overflow are counted.
module ccip_tx_elastic_buffer #(
  parameter int HDR_WIDTH     = 80,
  parameter int DATA_WIDTH    = 512,
  parameter int DEPTH         = 16,
  parameter int ALMFULL_SLACK = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     pClk,
  input  logic                     pck_cp2af_softReset,
  input  logic [HDR_WIDTH-1:0]     in_hdr,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_valid,
  output logic                     in_almFull,
  input  logic                     shell_almFull,
  output logic [HDR_WIDTH-1:0]     out_hdr,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_WIDTH-1:0]     drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] SLACK_L = LW'(ALMFULL_SLACK);

  logic [HDR_WIDTH-1:0]  hdr_mem_q  [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];

  logic [AW-1:0]         wp_q, wp_d, rp_q, rp_d;
  logic [LW-1:0]         level_q, level_d;
  logic [HDR_WIDTH-1:0]  out_hdr_q, out_hdr_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;
  logic                  full, pop, push, drop;

  always_comb begin
    full        = (level_q == DEPTH_L);
    pop         = (level_q != '0) && !shell_almFull;
    // A full buffer still accepts when the same cycle frees a slot.
    push        = in_valid && (!full || pop);
    drop        = in_valid && full && !pop;

    wp_d        = wp_q;
    rp_d        = rp_q;
    level_d     = level_q;
    out_hdr_d   = out_hdr_q;
    out_data_d  = out_data_q;
    out_valid_d = pop;
    overflow_d  = overflow_q;
    drop_cnt_d  = drop_cnt_q;

    if (push) wp_d = wp_q + 1'b1;
    if (pop) begin
      rp_d       = rp_q + 1'b1;
      out_hdr_d  = hdr_mem_q[rp_q];
      out_data_d = data_mem_q[rp_q];
    end

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge pClk) begin
    if (pck_cp2af_softReset) begin
      wp_q        <= '0;
      rp_q        <= '0;
      level_q     <= '0;
      out_hdr_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      level_q     <= level_d;
      out_hdr_q   <= out_hdr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Storage is deliberately not cleared by reset; the pointers alone define validity.
  always_ff @(posedge pClk) begin
    if (!pck_cp2af_softReset && push) begin
      hdr_mem_q[wp_q]  <= in_hdr;
      data_mem_q[wp_q] <= in_data;
    end
  end

  assign in_almFull = (DEPTH_L - level_q) <= SLACK_L;
  assign out_hdr    = out_hdr_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_ccip_tx_elastic_buffer.sv
// tb/tb_ccip_tx_elastic_buffer.sv - vector-table bench for ccip_tx_elastic_buffer
// Small header/data widths and a 3-bit drop counter so saturation is reachable.
module tb_ccip_tx_elastic_buffer;

  localparam int HW = 16;
  localparam int DW = 16;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [HW-1:0] in_hdr;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_almFull;
  logic          shell_almFull;
  logic [HW-1:0] out_hdr;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic [4:0]    level;
  logic          overflow;
  logic [CW-1:0] drop_cnt;

  ccip_tx_elastic_buffer #(
    .HDR_WIDTH(HW), .DATA_WIDTH(DW), .DEPTH(16), .ALMFULL_SLACK(4), .CNT_WIDTH(CW)
  ) dut (
    .pClk(clk), .pck_cp2af_softReset(rst),
    .in_hdr(in_hdr), .in_data(in_data), .in_valid(in_valid), .in_almFull(in_almFull),
    .shell_almFull(shell_almFull),
    .out_hdr(out_hdr), .out_data(out_data), .out_valid(out_valid),
    .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          iv;
    logic [HW-1:0] hdr;
    logic          sh;
    logic          ev;
    logic [HW-1:0] eh;
    logic [4:0]    el;
    logic          eaf;
    logic          eof;
    logic [CW-1:0] edc;
  } vec_t;

  vec_t          vecs [128];
  int            nv = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  logic [HW-1:0] exp_q [$];

  task automatic add(input logic iv, input logic [HW-1:0] hdr, input logic sh,
                     input logic ev, input logic [HW-1:0] eh, input int el,
                     input logic eof, input int edc);
    vecs[nv].iv  = iv;
    vecs[nv].hdr = hdr;
    vecs[nv].sh  = sh;
    vecs[nv].ev  = ev;
    vecs[nv].eh  = eh;
    vecs[nv].el  = 5'(el);
    vecs[nv].eaf = ((16 - el) <= 4);
    vecs[nv].eof = eof;
    vecs[nv].edc = CW'(edc);
    nv++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic iv, input logic [HW-1:0] h, input logic sh);
    in_valid      = iv;
    in_hdr        = h;
    in_data       = h ^ 16'hA5A5;
    shell_almFull = sh;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent, rcvd, cyc;
    logic iv;

    rst = 1'b1;
    step(1'b0, '0, 1'b0);
    step(1'b1, 16'hDEAD, 1'b0);
    chk("reset.out_valid", 32'(out_valid), 0);
    chk("reset.level", 32'(level), 0);
    chk("reset.overflow", 32'(overflow), 0);
    chk("reset.drop_cnt", 32'(drop_cnt), 0);
    chk("reset.in_almFull", 32'(in_almFull), 0);
    chk("reset.out_hdr", 32'(out_hdr), 0);
    rst = 1'b0;

    // Pass-through: three back-to-back requests, output two edges after each push.
    add(1, 16'h0001, 0, 0, 16'h0000, 1, 0, 0);
    add(1, 16'h0002, 0, 1, 16'h0001, 1, 0, 0);
    add(1, 16'h0003, 0, 1, 16'h0002, 1, 0, 0);
    add(0, 16'h0000, 0, 1, 16'h0003, 0, 0, 0);
    add(0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0);
    // Backpressure: 12 held, almost-full only once free slots drop to 4.
    for (int k = 1; k <= 12; k++) add(1, 16'(16'h0010 + k), 1, 0, 16'h0000, k, 0, 0);
    for (int j = 1; j <= 12; j++) add(0, 16'h0000, 0, 1, 16'(16'h0010 + j), 12 - j, 0, 0);
    add(0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0);
    // Overflow: 20 pushes into 16 slots.
    for (int k = 1; k <= 20; k++)
      add(1, 16'(16'h0020 + k), 1, 0, 16'h0000, (k > 16) ? 16 : k, k > 16, (k > 16) ? k - 16 : 0);
    // Full with simultaneous push and pop: level holds at 16, no drops.
    for (int k = 1; k <= 6; k++) add(1, 16'(16'h0040 + k), 0, 1, 16'(16'h0020 + k), 16, 1, 4);
    // Further drops saturate the 3-bit counter at 7.
    for (int k = 1; k <= 4; k++) add(1, 16'(16'h0050 + k), 1, 0, 16'h0000, 16, 1, (4 + k > 7) ? 7 : 4 + k);
    // Drain: remaining originals, then the entries pushed while full.
    for (int j = 1; j <= 16; j++)
      add(0, 16'h0000, 0, 1, (j <= 10) ? 16'(16'h0026 + j) : 16'(16'h0040 + j - 10), 16 - j, 1, 7);
    add(0, 16'h0000, 0, 0, 16'h0000, 0, 1, 7);

    for (int i = 0; i < nv; i++) begin
      step(vecs[i].iv, vecs[i].hdr, vecs[i].sh);
      chk($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].ev));
      chk($sformatf("v%0d.level", i), 32'(level), 32'(vecs[i].el));
      chk($sformatf("v%0d.in_almFull", i), 32'(in_almFull), 32'(vecs[i].eaf));
      chk($sformatf("v%0d.overflow", i), 32'(overflow), 32'(vecs[i].eof));
      chk($sformatf("v%0d.drop_cnt", i), 32'(drop_cnt), 32'(vecs[i].edc));
      if (vecs[i].ev) begin
        chk($sformatf("v%0d.out_hdr", i), 32'(out_hdr), 32'(vecs[i].eh));
        chk($sformatf("v%0d.out_data", i), 32'(out_data), 32'(vecs[i].eh ^ 16'hA5A5));
      end
    end

    // Reset mid-operation with level 7 and out_valid high.
    for (int k = 1; k <= 8; k++) step(1'b1, 16'(16'h0060 + k), 1'b1);
    step(1'b0, '0, 1'b0);
    chk("midrst.pre_level", 32'(level), 7);
    chk("midrst.pre_out_valid", 32'(out_valid), 1);
    chk("midrst.pre_out_hdr", 32'(out_hdr), 32'h0061);
    rst = 1'b1;
    step(1'b1, 16'h0099, 1'b0);
    rst = 1'b0;
    chk("midrst.out_valid", 32'(out_valid), 0);
    chk("midrst.level", 32'(level), 0);
    chk("midrst.overflow", 32'(overflow), 0);
    chk("midrst.drop_cnt", 32'(drop_cnt), 0);
    chk("midrst.in_almFull", 32'(in_almFull), 0);
    step(1'b1, 16'h0077, 1'b0);
    chk("midrst.push_level", 32'(level), 1);
    chk("midrst.push_no_bypass", 32'(out_valid), 0);
    step(1'b0, '0, 1'b0);
    chk("midrst.new_valid", 32'(out_valid), 1);
    chk("midrst.new_hdr", 32'(out_hdr), 32'h0077);
    chk("midrst.new_level", 32'(level), 0);
    step(1'b0, '0, 1'b0);
    chk("midrst.idle_valid", 32'(out_valid), 0);

    // Wrap-around: 100 requests, random shell backpressure, AFU honours in_almFull.
    sent = 0;
    rcvd = 0;
    cyc  = 0;
    while (rcvd < 100 && cyc < 3000) begin
      iv = (sent < 100) && !in_almFull && ($urandom_range(0, 1) == 1);
      if (iv) exp_q.push_back(16'(16'h0100 + sent));
      step(iv, 16'(16'h0100 + sent), 1'($urandom_range(0, 1)));
      if (iv) sent++;
      if (out_valid) begin
        chk("wrap.unexpected_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
          logic [HW-1:0] e;
          e = exp_q.pop_front();
          chk("wrap.out_hdr", 32'(out_hdr), 32'(e));
          chk("wrap.out_data", 32'(out_data), 32'(e ^ 16'hA5A5));
        end
        rcvd++;
      end
      cyc++;
    end
    chk("wrap.received", 32'(rcvd), 100);
    chk("wrap.drop_cnt", 32'(drop_cnt), 0);
    chk("wrap.overflow", 32'(overflow), 0);
    chk("wrap.level", 32'(level), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
